sd_init_sequencer: RTL and testbench

Card-initialisation controller that sits above the SD command engine and drives the SD-mode power-up sequence: CMD0, CMD8, CMD55/ACMD41 polling loop, CMD2 and CMD3. It issues commands over a valid/ready handshake, interprets the returned responses, and reports card version, capacity class and RCA. It releases the bus clock to full speed when initialisation completes.

---
 rtl/sd_pkg.sv | 89 ++++++++
 rtl/sd_seq_timer.sv | 26 ++
 rtl/sd_init_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD card-initialisation sequencer: command
// constants, response/error/state encodings and the per-state command lookup.
package sd_pkg;

  localparam int unsigned TMR_W = 16;

  localparam logic [5:0] IDX_CMD0   = 6'd0;
  localparam logic [5:0] IDX_CMD8   = 6'd8;
  localparam logic [5:0] IDX_CMD55  = 6'd55;
  localparam logic [5:0] IDX_ACMD41 = 6'd41;
  localparam logic [5:0] IDX_CMD2   = 6'd2;
  localparam logic [5:0] IDX_CMD3   = 6'd3;

  localparam logic [31:0] ARG_NONE      = 32'h0000_0000;
  localparam logic [31:0] ARG_CMD8      = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41_V1 = 32'h00FF_8000;
  localparam logic [31:0] ARG_ACMD41_V2 = 32'h40FF_8000;
  localparam logic [11:0] CMD8_ECHO     = 12'h1AA;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_48   = 2'd1,
    RESP_136  = 2'd2
  } resp_type_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CMD8_ECHO    = 3'd1,
    ERR_CMD55_TO     = 3'd2,
    ERR_ACMD41_RETRY = 3'd3,
    ERR_ACMD41_TO    = 3'd4,
    ERR_CMD2_TO      = 3'd5,
    ERR_CMD3_TO      = 3'd6,
    ERR_RCA_ZERO     = 3'd7
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_CMD0,
    ST_CMD8,
    ST_CMD55,
    ST_ACMD41,
    ST_CMD2,
    ST_CMD3,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } st_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    resp_type_e  rtype;
  } cmd_t;

  // Command fields presented when a CMD state starts its ISSUE phase.
  function automatic cmd_t cmd_for(input st_e s, input logic v2);
    cmd_t c;
    c.index = IDX_CMD0;
    c.arg   = ARG_NONE;
    c.rtype = RESP_48;
    case (s)
      ST_CMD0:   c.rtype = RESP_NONE;
      ST_CMD8: begin
        c.index = IDX_CMD8;
        c.arg   = ARG_CMD8;
      end
      ST_CMD55:  c.index = IDX_CMD55;
      ST_ACMD41: begin
        c.index = IDX_ACMD41;
        c.arg   = v2 ? ARG_ACMD41_V2 : ARG_ACMD41_V1;
      end
      ST_CMD2: begin
        c.index = IDX_CMD2;
        c.rtype = RESP_136;
      end
      ST_CMD3:   c.index = IDX_CMD3;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sd_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero once expired.
module sd_seq_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sd_init_sequencer.sv
// SD-mode card initialisation: CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3,
// driving the command engine over valid/ready and decoding its responses.
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned ACMD41_RETRIES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        card_v2,
  output logic        ccs,
  output logic [15:0] rca,
  output logic        clk_fast_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [1:0]  cmd_resp_type,
  input  logic        resp_valid,
  input  logic        resp_timeout,
  input  logic [31:0] resp_data
);

  st_e         state;
  st_e         gap_target;
  phase_e      phase;
  err_e        err_q;
  logic [15:0] retry_cnt;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  st_e  issue_tgt;
  cmd_t issue_cmd;

  logic dec_fire;
  err_e dec_err;
  st_e  dec_target;

  logic unused_resp;
  assign unused_resp = ^resp_data[15:12];

  assign err_code = err_q;

  // The timer is reloaded in every state that does not count, so it already
  // holds the right span on the edge that enters POWERUP or GAP.
  assign tmr_load = !(state == ST_POWERUP || state == ST_GAP);
  assign tmr_val  = (state inside {ST_IDLE, ST_DONE, ST_ERROR}) ?
                    TMR_W'(POWERUP_CYCLES) : TMR_W'(GAP_CYCLES);

  sd_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign issue_tgt = (state == ST_POWERUP) ? ST_CMD0 : gap_target;
  assign issue_cmd = cmd_for(issue_tgt, card_v2);

  // Response decode for the WAIT phase; a timeout overrides a coincident valid.
  always_comb begin
    dec_fire   = 1'b0;
    dec_err    = ERR_NONE;
    dec_target = ST_IDLE;
    if (phase == PH_WAIT && (resp_valid || resp_timeout)) begin
      dec_fire = 1'b1;
      case (state)
        ST_CMD0: begin
          if (resp_timeout) dec_fire = 1'b0;
          else              dec_target = ST_CMD8;
        end
        ST_CMD8: begin
          if (resp_timeout || resp_data[11:0] == CMD8_ECHO) dec_target = ST_CMD55;
          else                                               dec_err    = ERR_CMD8_ECHO;
        end
        ST_CMD55: begin
          if (resp_timeout) dec_err    = ERR_CMD55_TO;
          else              dec_target = ST_ACMD41;
        end
        ST_ACMD41: begin
          if (resp_timeout)                                   dec_err    = ERR_ACMD41_TO;
          else if (resp_data[31])                             dec_target = ST_CMD2;
          else if (retry_cnt + 16'd1 == 16'(ACMD41_RETRIES)) dec_err    = ERR_ACMD41_RETRY;
          else                                                dec_target = ST_CMD55;
        end
        ST_CMD2: begin
          if (resp_timeout) dec_err    = ERR_CMD2_TO;
          else              dec_target = ST_CMD3;
        end
        ST_CMD3: begin
          if (resp_timeout)                 dec_err    = ERR_CMD3_TO;
          else if (resp_data[31:16] == '0)  dec_err    = ERR_RCA_ZERO;
          else                              dec_target = ST_DONE;
        end
        default: dec_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      gap_target    <= ST_IDLE;
      phase         <= PH_ISSUE;
      err_q         <= ERR_NONE;
      retry_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      card_v2       <= 1'b0;
      ccs           <= 1'b0;
      rca           <= '0;
      clk_fast_en   <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_index     <= '0;
      cmd_arg       <= '0;
      cmd_resp_type <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            error       <= 1'b0;
            err_q       <= ERR_NONE;
            card_v2     <= 1'b0;
            ccs         <= 1'b0;
            rca         <= '0;
            clk_fast_en <= 1'b0;
            retry_cnt   <= '0;
            busy        <= 1'b1;
            state       <= ST_POWERUP;
          end
        end
        ST_POWERUP, ST_GAP: begin
          if (tmr_zero) begin
            state         <= issue_tgt;
            phase         <= PH_ISSUE;
            cmd_valid     <= 1'b1;
            cmd_index     <= issue_cmd.index;
            cmd_arg       <= issue_cmd.arg;
            cmd_resp_type <= issue_cmd.rtype;
          end
        end
        default: begin
          if (phase == PH_ISSUE) begin
            if (cmd_valid && cmd_ready) begin
              cmd_valid <= 1'b0;
              phase     <= PH_WAIT;
            end
          end else if (dec_fire) begin
            if (state == ST_CMD8)
              card_v2 <= !resp_timeout && (resp_data[11:0] == CMD8_ECHO);
            if (state == ST_ACMD41 && !resp_timeout) begin
              if (resp_data[31]) ccs       <= resp_data[30] & card_v2;
              else               retry_cnt <= retry_cnt + 16'd1;
            end
            if (state == ST_CMD3 && !resp_timeout)
              rca <= resp_data[31:16];

            if (dec_err != ERR_NONE) begin
              state <= ST_ERROR;
              error <= 1'b1;
              err_q <= dec_err;
              busy  <= 1'b0;
            end else if (dec_target == ST_DONE) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              clk_fast_en <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state      <= ST_GAP;
              gap_target <= dec_target;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed, table-driven bench for sd_init_sequencer with a scripted engine.
module tb_sd_init_sequencer;

  localparam int unsigned P   = 16;
  localparam int unsigned G   = 4;
  localparam int unsigned RET = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, card_v2, ccs, clk_fast_en, cmd_valid;
  logic [2:0]  err_code;
  logic [15:0] rca;
  logic        cmd_ready = 1'b0;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_resp_type;
  logic        resp_valid = 1'b0;
  logic        resp_timeout = 1'b0;
  logic [31:0] resp_data = 32'h0;

  always #5 clk = ~clk;

  sd_init_sequencer #(
    .POWERUP_CYCLES (P),
    .GAP_CYCLES     (G),
    .ACMD41_RETRIES (RET)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .card_v2       (card_v2),
    .ccs           (ccs),
    .rca           (rca),
    .clk_fast_en   (clk_fast_en),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .cmd_resp_type (cmd_resp_type),
    .resp_valid    (resp_valid),
    .resp_timeout  (resp_timeout),
    .resp_data     (resp_data)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    int unsigned dly;
    logic        rv;
    logic        rto;
    logic [31:0] rd;
  } step_t;

  // fin = {busy, done, error, err_code, card_v2, ccs, rca, clk_fast_en}
  typedef struct {
    int unsigned first;
    int unsigned n;
    logic        chk_final;
    logic [24:0] fin;
  } scn_t;

  step_t steps[$];
  scn_t  scns[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                              input int unsigned dly, input logic rv, input logic rto,
                              input logic [31:0] rd);
    step_t s;
    s.idx = idx; s.arg = arg; s.rt = rt; s.dly = dly; s.rv = rv; s.rto = rto; s.rd = rd;
    steps.push_back(s);
  endfunction

  function automatic void scn(input int unsigned n, input logic cf, input logic [24:0] fin);
    scn_t c;
    c.n = n;
    c.first = steps.size() - n;
    c.chk_final = cf;
    c.fin = fin;
    scns.push_back(c);
  endfunction

  task automatic run_scn(input int unsigned s);
    scn_t        c;
    step_t       st;
    int unsigned k;
    logic        stable, seen;
    logic [39:0] f0;
    c = scns[s];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1'b1));
    for (int unsigned i = 0; i < c.n; i++) begin
      st = steps[c.first + i];
      k = 0;
      while (!cmd_valid && k < 400) begin
        @(negedge clk);
        k++;
      end
      chk("cmd_latency", 128'(k), 128'((i == 0) ? P + 1 : G + 1));
      if (!cmd_valid) return;
      chk("cmd_fields", 128'({cmd_index, cmd_arg, cmd_resp_type}), 128'({st.idx, st.arg, st.rt}));
      f0 = {cmd_index, cmd_arg, cmd_resp_type};
      stable = 1'b1;
      for (int unsigned d = 0; d < st.dly; d++) begin
        @(negedge clk);
        if ({cmd_valid, cmd_index, cmd_arg, cmd_resp_type} !== {1'b1, f0}) stable = 1'b0;
      end
      if (st.dly > 0) chk("hold_stable", 128'(stable), 128'(1'b1));
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("valid_drop", 128'(cmd_valid), 128'(1'b0));
      repeat (2) @(negedge clk);
      resp_valid   = st.rv;
      resp_timeout = st.rto;
      resp_data    = st.rd;
      @(negedge clk);
      resp_valid   = 1'b0;
      resp_timeout = 1'b0;
    end
    if (c.chk_final) begin
      chk("final_outputs",
          128'({busy, done, error, err_code, card_v2, ccs, rca, clk_fast_en}), 128'(c.fin));
      if (c.fin[23]) begin
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(1'b0));
      end
      if (c.fin[22]) begin
        seen = 1'b0;
        repeat (P + 3 * G) begin
          @(negedge clk);
          if (cmd_valid) seen = 1'b1;
        end
        chk("quiet_after_error", 128'(seen), 128'(1'b0));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // 0: v2 card, two ACMD41 retries, slow cmd_ready on CMD8 and first ACMD41
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 5, 1, 0, 32'h0000_01AA);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0000_0120);
    add(6'd41, 32'h40FF_8000, 2'd1, 5, 1, 0, 32'h00FF_8000);
    add(6'd55, 32'h0,         2'd1, 1, 1, 0, 32'h0000_0120);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 1, 0, 32'h00FF_8000);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0000_0120);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 1, 0, 32'hC0FF_8000);
    add(6'd2,  32'h0,         2'd2, 0, 1, 0, 32'h0);
    add(6'd3,  32'h0,         2'd1, 2, 1, 0, 32'h1234_0000);
    scn(10, 1, {1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 16'h1234, 1'b1});
    // 1: retry exhaustion after exactly three ACMD41s
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 1, 0, 32'h0000_01AA);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 1, 0, 32'h00FF_8000);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 1, 0, 32'h00FF_8000);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 1, 0, 32'h00FF_8000);
    scn(8, 1, {1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 16'h0, 1'b0});
    // 2: bad CMD8 echo
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 1, 0, 32'h0000_01AB);
    scn(2, 1, {1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0, 1'b0});
    // 3: v1 card; CMD8 valid and timeout together must take the timeout path
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 1, 1, 32'h0000_01AA);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h00FF_8000, 2'd1, 0, 1, 0, 32'hC0FF_8000);
    add(6'd2,  32'h0,         2'd2, 0, 1, 0, 32'h0);
    add(6'd3,  32'h0,         2'd1, 0, 1, 0, 32'hABCD_0000);
    scn(6, 1, {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'hABCD, 1'b1});
    // 4: CMD3 returns RCA zero
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 0, 1, 32'h0);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h00FF_8000, 2'd1, 0, 1, 0, 32'h80FF_8000);
    add(6'd2,  32'h0,         2'd2, 0, 1, 0, 32'h0);
    add(6'd3,  32'h0,         2'd1, 0, 1, 0, 32'h0000_FFFF);
    scn(6, 1, {1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 1'b0});
    // 5: CMD55 timeout
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 1, 0, 32'h0000_01AA);
    add(6'd55, 32'h0,         2'd1, 0, 0, 1, 32'h0);
    scn(3, 1, {1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 16'h0, 1'b0});
    // 6: stop in ACMD41 WAIT with no response, then reset
    add(6'd0,  32'h0,         2'd0, 0, 1, 0, 32'h0);
    add(6'd8,  32'h0000_01AA, 2'd1, 0, 1, 0, 32'h0000_01AA);
    add(6'd55, 32'h0,         2'd1, 0, 1, 0, 32'h0);
    add(6'd41, 32'h40FF_8000, 2'd1, 0, 0, 0, 32'h0);
    scn(4, 0, 25'h0);

    repeat (3) @(negedge clk);
    chk("reset_state",
        128'({busy, done, error, err_code, card_v2, ccs, rca, clk_fast_en,
              cmd_valid, cmd_index, cmd_arg, cmd_resp_type}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int unsigned s = 0; s < 7; s++) run_scn(s);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid_acmd41",
        128'({busy, done, error, err_code, card_v2, ccs, rca, clk_fast_en,
              cmd_valid, cmd_index, cmd_arg, cmd_resp_type}), 128'(0));
    @(negedge clk);
    run_scn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
